// File: rtl/shift_sequencer_if.sv
// Bundle of request, Shift-unit and response signals around the shift sequencer.
// The slave modport is the sequencer's view; master is the issue/consumer/Shift-unit side.
interface shift_sequencer_if #(
    parameter int W  = 8,
    parameter int AW = 3
);
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [W-1:0]  req_data0;
    logic [W-1:0]  req_data1;
    logic          req_dir0;
    logic          req_dir1;
    logic [AW-1:0] req_amt0;
    logic [AW-1:0] req_amt1;
    logic [W-1:0]  sh_source;
    logic          sh_shift;
    logic [2:0]    sh_shamt;
    logic [W-1:0]  sh_result;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_result;
    logic          rsp_id;
    logic          busy;

    modport slave (
        input  req_valid, req_data0, req_data1, req_dir0, req_dir1, req_amt0, req_amt1,
        output req_ready,
        output sh_source, sh_shift, sh_shamt,
        input  sh_result,
        output rsp_valid, rsp_result, rsp_id, busy,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_data0, req_data1, req_dir0, req_dir1, req_amt0, req_amt1,
        input  req_ready,
        input  sh_source, sh_shift, sh_shamt,
        output sh_result,
        input  rsp_valid, rsp_result, rsp_id, busy,
        output rsp_ready
    );
endinterface

// File: rtl/shift_sequencer.sv
// Round-robin sharing of a 3-bit-per-pass Shift unit between two requesters,
// iterating through a working register so each request can shift 0..7.
module shift_sequencer #(
    parameter int W    = 8,
    parameter int AW   = 3,
    parameter int STEP = 3
) (
    input  logic               clk,
    input  logic               rst,
    shift_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        RESP  = 2'b10
    } state_t;

    state_t        state_reg, state_next;
    logic [W-1:0]  acc_reg;
    logic [AW-1:0] rem_reg;
    logic          dir_reg;
    logic          id_reg;
    logic          last_reg;

    logic          accept;
    logic          grant;
    logic [AW-1:0] amt_in;
    logic [AW-1:0] step;
    logic [AW-1:0] rem_next;

    // Both valid: alternate away from the last winner; otherwise the sole valid one wins.
    assign grant    = (&bus.req_valid) ? ~last_reg : bus.req_valid[1];
    assign accept   = (state_reg == IDLE) && (|bus.req_valid);
    assign amt_in   = grant ? bus.req_amt1 : bus.req_amt0;
    assign step     = (rem_reg > AW'(STEP)) ? AW'(STEP) : rem_reg;
    assign rem_next = rem_reg - step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = (amt_in != '0) ? SHIFT : RESP;
            SHIFT:   if (rem_next == '0) state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = 2'b00;
        bus.sh_shift  = 1'b0;
        bus.sh_shamt  = 3'b000;
        bus.rsp_valid = 1'b0;
        bus.busy      = 1'b1;
        case (state_reg)
            IDLE: begin
                bus.busy = 1'b0;
                if (accept) bus.req_ready = grant ? 2'b10 : 2'b01;
            end
            SHIFT: begin
                bus.sh_shift = 1'b1;
                bus.sh_shamt = {dir_reg, step[1:0]};
            end
            RESP:    bus.rsp_valid = 1'b1;
            default: bus.busy = 1'b1;
        endcase
    end

    assign bus.sh_source  = acc_reg;
    assign bus.rsp_result = acc_reg;
    assign bus.rsp_id     = id_reg;

    // Operands are captured only on accept; later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg  <= '0;
            rem_reg  <= '0;
            dir_reg  <= 1'b0;
            id_reg   <= 1'b0;
            last_reg <= 1'b1;
        end else if (accept) begin
            acc_reg  <= grant ? bus.req_data1 : bus.req_data0;
            rem_reg  <= amt_in;
            dir_reg  <= grant ? bus.req_dir1 : bus.req_dir0;
            id_reg   <= grant;
            last_reg <= grant;
        end else if (state_reg == SHIFT) begin
            acc_reg  <= bus.sh_result;
            rem_reg  <= rem_next;
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural model of the combinational Shift unit.
module tb_shift_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    shift_sequencer_if #(.W(8), .AW(3)) sif ();

    shift_sequencer #(.W(8), .AW(3), .STEP(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    always #5 clk = ~clk;

    // Shift unit: logical shift by Shamt[1:0], direction Shamt[2] (1 = right)
    assign sif.sh_result = !sif.sh_shift ? sif.sh_source :
                           sif.sh_shamt[2] ? (sif.sh_source >> sif.sh_shamt[1:0])
                                           : (sif.sh_source << sif.sh_shamt[1:0]);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        sif.req_valid = 2'b00;
        sif.req_data0 = 8'h00;
        sif.req_data1 = 8'h00;
        sif.req_dir0  = 1'b0;
        sif.req_dir1  = 1'b0;
        sif.req_amt0  = 3'd0;
        sif.req_amt1  = 3'd0;
        sif.rsp_ready = 1'b0;

        // Reset state
        @(negedge clk); #1;
        check("rst_ready", sif.req_ready, 2'b00);
        check("rst_busy", sif.busy, 1'b0);
        check("rst_rspv", sif.rsp_valid, 1'b0);
        check("rst_shift", sif.sh_shift, 1'b0);
        check("rst_shamt", sif.sh_shamt, 3'b000);
        check("rst_src", sif.sh_source, 8'h00);
        check("rst_result", sif.rsp_result, 8'h00);
        @(negedge clk); rst = 1'b0;

        // 1: req0 0xB5 left 5
        @(negedge clk);
        sif.req_valid = 2'b01; sif.req_data0 = 8'hB5; sif.req_dir0 = 1'b0; sif.req_amt0 = 3'd5;
        #1 check("t1_ready", sif.req_ready, 2'b01);
        @(negedge clk);
        sif.req_valid = 2'b00; sif.req_data0 = 8'h00; sif.req_amt0 = 3'd0;
        #1 check("t1_shamt1", sif.sh_shamt, 3'b011);
        check("t1_shift1", sif.sh_shift, 1'b1);
        check("t1_src1", sif.sh_source, 8'hB5);
        @(negedge clk); #1;
        check("t1_shamt2", sif.sh_shamt, 3'b010);
        check("t1_src2", sif.sh_source, 8'hA8);
        @(negedge clk); #1;
        check("t1_rspv", sif.rsp_valid, 1'b1);
        check("t1_result", sif.rsp_result, 8'hA0);
        check("t1_id", sif.rsp_id, 1'b0);
        sif.rsp_ready = 1'b1;
        @(negedge clk); #1;
        check("t1_done", sif.rsp_valid, 1'b0);
        check("t1_busy", sif.busy, 1'b0);
        sif.rsp_ready = 1'b0;

        // 2: req1 0xFF right 7
        sif.req_valid = 2'b10; sif.req_data1 = 8'hFF; sif.req_dir1 = 1'b1; sif.req_amt1 = 3'd7;
        #1 check("t2_ready", sif.req_ready, 2'b10);
        @(negedge clk);
        sif.req_valid = 2'b00;
        #1 check("t2_shamt1", sif.sh_shamt, 3'b111);
        @(negedge clk); #1;
        check("t2_shamt2", sif.sh_shamt, 3'b111);
        @(negedge clk); #1;
        check("t2_shamt3", sif.sh_shamt, 3'b101);
        @(negedge clk); #1;
        check("t2_rspv", sif.rsp_valid, 1'b1);
        check("t2_result", sif.rsp_result, 8'h01);
        check("t2_id", sif.rsp_id, 1'b1);
        sif.rsp_ready = 1'b1;
        @(negedge clk); sif.rsp_ready = 1'b0;

        // 3: req0 0x3C left 0
        sif.req_valid = 2'b01; sif.req_data0 = 8'h3C; sif.req_dir0 = 1'b0; sif.req_amt0 = 3'd0;
        #1 check("t3_ready", sif.req_ready, 2'b01);
        @(negedge clk);
        sif.req_valid = 2'b00;
        #1 check("t3_shift", sif.sh_shift, 1'b0);
        check("t3_rspv", sif.rsp_valid, 1'b1);
        check("t3_result", sif.rsp_result, 8'h3C);
        sif.rsp_ready = 1'b1;
        @(negedge clk); sif.rsp_ready = 1'b0;

        // 4: both valid after reset -> grants alternate starting with 0
        #2 rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        sif.req_data0 = 8'h01; sif.req_dir0 = 1'b0; sif.req_amt0 = 3'd1;
        sif.req_data1 = 8'h80; sif.req_dir1 = 1'b1; sif.req_amt1 = 3'd1;
        sif.req_valid = 2'b11; sif.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("t4_ready", sif.req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            @(negedge clk); #1;
            check("t4_shift", sif.sh_shift, 1'b1);
            @(negedge clk); #1;
            check("t4_rspv", sif.rsp_valid, 1'b1);
            check("t4_id", sif.rsp_id, (i % 2 == 0) ? 1'b0 : 1'b1);
            check("t4_result", sif.rsp_result, (i % 2 == 0) ? 8'h02 : 8'h40);
            @(negedge clk);
        end
        sif.req_valid = 2'b00; sif.rsp_ready = 1'b0;

        // 5: response backpressure
        @(negedge clk);
        sif.req_valid = 2'b01; sif.req_data0 = 8'h0F; sif.req_amt0 = 3'd0;
        @(negedge clk);
        sif.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1 check("t5_rspv", sif.rsp_valid, 1'b1);
            check("t5_result", sif.rsp_result, 8'h0F);
            check("t5_id", sif.rsp_id, 1'b0);
            check("t5_ready", sif.req_ready, 2'b00);
            check("t5_busy", sif.busy, 1'b1);
            @(negedge clk);
        end
        sif.req_valid = 2'b00; sif.rsp_ready = 1'b1;
        @(negedge clk); #1;
        check("t5_idle", sif.busy, 1'b0);
        check("t5_rspv0", sif.rsp_valid, 1'b0);
        sif.rsp_ready = 1'b0;

        // 6: reset during SHIFT aborts the request
        @(negedge clk);
        sif.req_valid = 2'b10; sif.req_data1 = 8'hFF; sif.req_dir1 = 1'b1; sif.req_amt1 = 3'd7;
        @(negedge clk);
        sif.req_valid = 2'b00;
        #1 check("t6_inshift", sif.sh_shift, 1'b1);
        #1 rst = 1'b1;
        #1 check("t6_busy", sif.busy, 1'b0);
        check("t6_rspv", sif.rsp_valid, 1'b0);
        check("t6_acc", sif.sh_source, 8'h00);
        check("t6_shift", sif.sh_shift, 1'b0);
        @(negedge clk); rst = 1'b0;
        sif.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("t6_norsp", sif.rsp_valid, 1'b0);
        end
        sif.rsp_ready = 1'b0;
        sif.req_valid = 2'b01; sif.req_data0 = 8'h81; sif.req_dir0 = 1'b0; sif.req_amt0 = 3'd1;
        #1 check("t6_ready", sif.req_ready, 2'b01);
        @(negedge clk);
        sif.req_valid = 2'b00;
        #1 check("t6_shamt", sif.sh_shamt, 3'b001);
        check("t6_src", sif.sh_source, 8'h81);
        @(negedge clk); #1;
        check("t6_rspv2", sif.rsp_valid, 1'b1);
        check("t6_result", sif.rsp_result, 8'h02);
        check("t6_id", sif.rsp_id, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
